intdiv_seq: RTL and testbench

INTDIV_SEQ -- requirements
Module: intdiv_seq

---
 rtl/intdiv_seq.sv | 157 +++++++++++++++
 tb/tb_intdiv_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_seq.sv
// Sequential signed divider, non-restoring, one quotient digit per cycle.
// Ports: clk, rst (sync, active-high), start, dividend, divisor in;
//   busy, done (1-cycle pulse), quot, rem, ovf, dbz out (all registered).
module intdiv_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CONV
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dvd_q;
  logic             sa_q;
  logic             sb_q;
  logic             zdiv_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] n_q;
  logic [RW-1:0]    r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             ovf_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_abs_d;
  logic [WIDTH-1:0] b_abs_d;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    r_sh_d;
  logic [RW-1:0]    r_d;
  logic             corr;
  logic [RW-1:0]    r_fix_d;
  logic [WIDTH:0]   pn_d;
  logic [WIDTH:0]   np_d;
  logic [WIDTH:0]   corr_ext;
  logic [WIDTH:0]   q_d;
  logic [WIDTH-1:0] rmag_d;
  logic [WIDTH-1:0] rem_d;
  logic             ovf_d;

  // Magnitudes as unsigned; most-negative maps to 2^(WIDTH-1).
  assign a_abs_d = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_abs_d = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign b_ext  = {2'b00, b_q};
  assign r_sh_d = {r_q[RW-2:0], a_q[cnt_q]};
  assign r_d    = r_q[RW-1] ? r_sh_d + b_ext
                            : r_sh_d - b_ext;

  assign corr    = r_q[RW-1];
  assign r_fix_d = corr ? r_q + b_ext : r_q;
  assign rmag_d  = r_fix_d[WIDTH-1:0];
  assign rem_d   = sa_q ? -rmag_d : rmag_d;

  // Negative results use N-P so the correction becomes +1.
  assign pn_d     = {1'b0, p_q} - {1'b0, n_q};
  assign np_d     = {1'b0, n_q} - {1'b0, p_q};
  assign corr_ext = {{WIDTH{1'b0}}, corr};
  assign q_d      = (sa_q ^ sb_q) ? np_d + corr_ext
                                  : pn_d - corr_ext;
  assign ovf_d    = q_d[WIDTH] ^ q_d[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      p_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q    <= a_abs_d;
            b_q    <= b_abs_d;
            dvd_q  <= dividend;
            sa_q   <= dividend[WIDTH-1];
            sb_q   <= divisor[WIDTH-1];
            zdiv_q <= (divisor == '0);
            p_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
            state_q <= (divisor == '0) ? CONV : ITER;
          end
        end
        ITER: begin
          r_q <= r_d;
          if (r_q[RW-1]) n_q[cnt_q] <= 1'b1;
          else           p_q[cnt_q] <= 1'b1;
          if (cnt_q == '0) state_q <= CONV;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CONV: begin
          if (zdiv_q) begin
            quot_q <= '1;
            rem_q  <= dvd_q;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b1;
          end else begin
            quot_q <= q_d[WIDTH-1:0];
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            dbz_q  <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed bench for intdiv_seq, WIDTH=5.
// Each task drives one scenario and checks results inline.
module tb_intdiv_seq;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         ovf;
  logic         dbz;

  int tests;
  int fails;

  intdiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one division, scramble operands after acceptance,
  // return at the negedge of the done cycle (or on timeout).
  task automatic do_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output int           lat,
    output int           bcnt,
    output logic         got
  );
    int k;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    lat = -1;
    bcnt = 0;
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = k;
      end else if (busy) begin
        bcnt++;
      end
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, ovf, dbz} !== 4'b0) begin
      $display("FAIL reset_flags got=%b want=0000",
               {busy, done, ovf, dbz});
      fails++;
    end
    tests++;
    if ({quot, rem} !== '0) begin
      $display("FAIL reset_data quot=%b rem=%b want 0",
               quot, rem);
      fails++;
    end
  endtask

  task automatic test_basic;
    int lat;
    int bcnt;
    logic got;
    do_op(5'd7, 5'd2, lat, bcnt, got);
    tests++;
    if (!got) begin
      $display("FAIL basic_timeout no done");
      fails++;
    end
    tests++;
    if (lat !== 6) begin
      $display("FAIL basic_latency got=%0d want=6", lat);
      fails++;
    end
    tests++;
    if (bcnt !== 6) begin
      $display("FAIL basic_busy_cycles got=%0d want=6", bcnt);
      fails++;
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL basic_busy_at_done got=%b want=0", busy);
      fails++;
    end
    tests++;
    if ({quot, rem, ovf, dbz} !== {5'b00011, 5'b00001, 2'b00}) begin
      $display("FAIL basic_result q=%b r=%b o=%b z=%b want 00011 00001 0 0",
               quot, rem, ovf, dbz);
      fails++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({done, quot, rem} !== {1'b0, 5'b00011, 5'b00001}) begin
      $display("FAIL basic_hold d=%b q=%b r=%b want 0 00011 00001",
               done, quot, rem);
      fails++;
    end
  endtask

  task automatic test_dbz;
    int lat;
    int bcnt;
    logic got;
    do_op(5'd5, 5'd0, lat, bcnt, got);
    tests++;
    if (!got || lat !== 1 || bcnt !== 1) begin
      $display("FAIL dbz_timing got=%b lat=%0d busy=%0d want 1 1 1",
               got, lat, bcnt);
      fails++;
    end
    tests++;
    if ({quot, rem, ovf, dbz} !== {5'b11111, 5'b00101, 2'b01}) begin
      $display("FAIL dbz_result q=%b r=%b o=%b z=%b want 11111 00101 0 1",
               quot, rem, ovf, dbz);
      fails++;
    end
  endtask

  task automatic test_signs;
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic [W-1:0] vq [6];
    logic [W-1:0] vr [6];
    int lat;
    int bcnt;
    logic got;
    va = '{5'b10011, 5'b01101, 5'b10011,
           5'b11001, 5'b01111, 5'b10000};
    vb = '{5'b00011, 5'b11101, 5'b11101,
           5'b00010, 5'b10000, 5'b10000};
    vq = '{5'b11100, 5'b11100, 5'b00100,
           5'b11101, 5'b00000, 5'b00001};
    vr = '{5'b11111, 5'b00001, 5'b11111,
           5'b11111, 5'b01111, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], lat, bcnt, got);
      tests++;
      if (!got || lat !== 6 ||
          {quot, rem, ovf, dbz} !== {vq[i], vr[i], 2'b00}) begin
        $display("FAIL signs_%0d got=%b lat=%0d q=%b r=%b o=%b z=%b want q=%b r=%b",
                 i, got, lat, quot, rem, ovf, dbz, vq[i], vr[i]);
        fails++;
      end
    end
  endtask

  task automatic test_ovf;
    int lat;
    int bcnt;
    logic got;
    do_op(5'b10000, 5'b11111, lat, bcnt, got);
    tests++;
    if (!got || {quot, rem, ovf, dbz} !== {5'b10000, 5'b00000, 2'b10}) begin
      $display("FAIL ovf_neg1 q=%b r=%b o=%b z=%b want 10000 00000 1 0",
               quot, rem, ovf, dbz);
      fails++;
    end
    do_op(5'b10000, 5'b00001, lat, bcnt, got);
    tests++;
    if (!got || {quot, rem, ovf, dbz} !== {5'b10000, 5'b00000, 2'b00}) begin
      $display("FAIL ovf_pos1 q=%b r=%b o=%b z=%b want 10000 00000 0 0",
               quot, rem, ovf, dbz);
      fails++;
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int bcnt;
    int dcnt;
    logic got;
    @(negedge clk);
    start = 1'b1;
    dividend = 5'd13;
    divisor = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    dividend = 5'd9;
    divisor = 5'd4;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    tests++;
    if ({busy, done, ovf, dbz, quot, rem} !== '0) begin
      $display("FAIL abort_outputs b=%b d=%b o=%b z=%b q=%b r=%b want 0",
               busy, done, ovf, dbz, quot, rem);
      fails++;
    end
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    tests++;
    if (dcnt !== 0) begin
      $display("FAIL abort_no_done got=%0d pulses want=0", dcnt);
      fails++;
    end
    do_op(5'd9, 5'd4, lat, bcnt, got);
    tests++;
    if (!got || {quot, rem, ovf, dbz} !== {5'b00010, 5'b00001, 2'b00}) begin
      $display("FAIL abort_next q=%b r=%b o=%b z=%b want 00010 00001 0 0",
               quot, rem, ovf, dbz);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    int first;
    int second;
    int dcnt;
    logic b7;
    logic d7;
    logic [W-1:0] q6;
    logic [W-1:0] r6;
    @(negedge clk);
    start = 1'b1;
    dividend = 5'd6;
    divisor = 5'd3;
    @(posedge clk);
    first = -1;
    second = -1;
    dcnt = 0;
    b7 = 1'b0;
    d7 = 1'b1;
    q6 = '0;
    r6 = '1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 13) start = 1'b0;
      if (done) begin
        dcnt++;
        if (first < 0) begin
          first = k;
          q6 = quot;
          r6 = rem;
        end else if (second < 0) begin
          second = k;
        end
      end
      if (k == 7) begin
        b7 = busy;
        d7 = done;
      end
    end
    tests++;
    if (first !== 6 || q6 !== 5'b00010 || r6 !== 5'b00000) begin
      $display("FAIL b2b_first at=%0d q=%b r=%b want 6 00010 00000",
               first, q6, r6);
      fails++;
    end
    tests++;
    if (b7 !== 1'b1 || d7 !== 1'b0) begin
      $display("FAIL b2b_reaccept busy=%b done=%b want 1 0", b7, d7);
      fails++;
    end
    tests++;
    if (second !== 13 || dcnt !== 2 || busy !== 1'b0) begin
      $display("FAIL b2b_second at=%0d pulses=%0d busy=%b want 13 2 0",
               second, dcnt, busy);
      fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_dbz();
    test_signs();
    test_ovf();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
